// File: rtl/serial_cmp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : cmp_pkg
// Brief  : Shared state encoding and default operand width for serial_cmp_ctrl.
// Rev    : 1.0
// ============================================================================
package cmp_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/serial_cmp_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : serial_cmp_ctrl_if
// Brief  : Request/result bundle between a requester and serial_cmp_ctrl.
// Rev    : 1.0
// ============================================================================
interface serial_cmp_ctrl_if
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic             lt;
    logic             gt;
    logic             eq;

    modport master (
        output start, op_a, op_b,
        input  busy, done, lt, gt, eq
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, lt, gt, eq
    );

endinterface
`default_nettype wire

// File: rtl/serial_cmp_ctrl_slice.sv
`default_nettype none
// ============================================================================
// Module : cmp2_slice
// Brief  : Combinational 2-bit unsigned magnitude compare.
// Rev    : 1.0
// ============================================================================
module cmp2_slice (
    input  wire logic [1:0] a_i,
    input  wire logic [1:0] b_i,
    output logic            lt_o,
    output logic            gt_o,
    output logic            eq_o
);

    assign lt_o = (a_i < b_i);
    assign gt_o = (a_i > b_i);
    assign eq_o = (a_i == b_i);

endmodule
`default_nettype wire

// File: rtl/serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module : serial_cmp_ctrl
// Brief  : Digit-serial unsigned comparator, MSB 2-bit digit first, early exit.
// Rev    : 1.0
// ============================================================================
module serial_cmp_ctrl
    import cmp_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = WIDTH / 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_cmp_ctrl_if.slave   bus
);

    localparam int             IDXW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(DIGITS - 1);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q,   idx_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic             lt_q,    lt_d;
    logic             gt_q,    gt_d;
    logic             eq_q,    eq_d;

    logic [1:0]       a_dig;
    logic [1:0]       b_dig;
    logic             slice_lt;
    logic             slice_gt;
    logic             slice_eq;

    assign a_dig = a_q[{idx_q, 1'b0} +: 2];
    assign b_dig = b_q[{idx_q, 1'b0} +: 2];

    cmp2_slice u_slice (
        .a_i  (a_dig),
        .b_i  (b_dig),
        .lt_o (slice_lt),
        .gt_o (slice_gt),
        .eq_o (slice_eq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= IDX_TOP;
            a_q     <= '0;
            b_q     <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = COMPARE;
                    idx_d   = IDX_TOP;
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                end
            end
            COMPARE: begin
                // First unequal digit decides; equal digits walk toward the LSB.
                if (!slice_eq) begin
                    lt_d    = slice_lt;
                    gt_d    = slice_gt;
                    state_d = DONE;
                end else if (idx_q != '0) begin
                    idx_d   = idx_q - IDXW'(1);
                end else begin
                    eq_d    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = (state_q == DONE);
    assign bus.lt   = lt_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_serial_cmp_ctrl
// Brief  : Scoreboard bench for serial_cmp_ctrl at WIDTH=8 and WIDTH=4.
// Rev    : 1.0
// ============================================================================
module tb_serial_cmp_ctrl;

    typedef struct {
        logic [2:0] res;
        int         done_cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t q8[$];
    exp_t q4[$];

    serial_cmp_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_cmp_ctrl_if #(.WIDTH(4)) bus4 ();

    serial_cmp_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_cmp_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int digits_examined(input logic [7:0] a, input logic [7:0] b, input int nd);
        for (int k = nd - 1; k >= 0; k--) begin
            if (a[2*k +: 2] != b[2*k +: 2]) return nd - k;
        end
        return nd;
    endfunction

    function automatic exp_t make_exp(input logic [7:0] a, input logic [7:0] b, input int nd, input int acc);
        exp_t e;
        e.res      = {a < b, a > b, a == b};
        e.done_cyc = acc + digits_examined(a, b, nd);
        return e;
    endfunction

    // Result monitors: pop on done, then confirm busy drop and result hold one cycle later.
    logic       hold8, hold4;
    logic [2:0] last8, last4;
    initial begin hold8 = 1'b0; hold4 = 1'b0; last8 = '0; last4 = '0; end

    always @(negedge clk) begin
        exp_t e;
        if (hold8) begin
            hold8 = 1'b0;
            chk("busy8_fall", bus8.busy, 1'b0);
            chk("hold8", {bus8.lt, bus8.gt, bus8.eq}, last8);
        end
        if (bus8.done) begin
            if (q8.size() == 0) begin
                chk("spurious_done8", bus8.done, 1'b0);
            end else begin
                e = q8.pop_front();
                chk("res8", {bus8.lt, bus8.gt, bus8.eq}, e.res);
                chk("lat8", cyc, e.done_cyc);
                chk("busy8_at_done", bus8.busy, 1'b1);
                hold8 = 1'b1;
                last8 = e.res;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (hold4) begin
            hold4 = 1'b0;
            chk("busy4_fall", bus4.busy, 1'b0);
            chk("hold4", {bus4.lt, bus4.gt, bus4.eq}, last4);
        end
        if (bus4.done) begin
            if (q4.size() == 0) begin
                chk("spurious_done4", bus4.done, 1'b0);
            end else begin
                e = q4.pop_front();
                chk("res4", {bus4.lt, bus4.gt, bus4.eq}, e.res);
                chk("lat4", cyc, e.done_cyc);
                hold4 = 1'b1;
                last4 = e.res;
            end
        end
    end

    task automatic wait_idle8;
        int n = 0;
        while (bus8.busy && n < 50) begin @(negedge clk); n++; end
        if (bus8.busy) chk("idle8_timeout", bus8.busy, 1'b0);
    endtask

    task automatic wait_idle4;
        int n = 0;
        while (bus4.busy && n < 50) begin @(negedge clk); n++; end
        if (bus4.busy) chk("idle4_timeout", bus4.busy, 1'b0);
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input bit scramble);
        wait_idle8();
        bus8.op_a  = a;
        bus8.op_b  = b;
        bus8.start = 1'b1;
        q8.push_back(make_exp(a, b, 4, cyc + 1));
        @(negedge clk);
        bus8.start = 1'b0;
        if (scramble) begin
            bus8.op_a = 8'hFF;
            bus8.op_b = 8'hFF;
        end
    endtask

    task automatic drive4(input logic [3:0] a, input logic [3:0] b);
        wait_idle4();
        bus4.op_a  = a;
        bus4.op_b  = b;
        bus4.start = 1'b1;
        q4.push_back(make_exp({4'h0, a}, {4'h0, b}, 2, cyc + 1));
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    initial begin
        int   n;
        int   d;
        exp_t e;
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        bus8.start = 1'b0; bus8.op_a = '0; bus8.op_b = '0;
        bus4.start = 1'b0; bus4.op_a = '0; bus4.op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy8", bus8.busy, 1'b0);
        chk("rst_done8", bus8.done, 1'b0);
        chk("rst_res8", {bus8.lt, bus8.gt, bus8.eq}, 3'b000);
        chk("rst_busy4", bus4.busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        drive8(8'hC0, 8'h40, 1'b0);
        chk("cleared_while_busy", {bus8.lt, bus8.gt, bus8.eq}, 3'b000);
        drive8(8'hA5, 8'hA5, 1'b0);
        drive8(8'h12, 8'h13, 1'b1);

        // start held high: second accept only once IDLE is reached after DONE
        wait_idle8();
        bus8.op_a  = 8'h00;
        bus8.op_b  = 8'h01;
        bus8.start = 1'b1;
        d = digits_examined(8'h00, 8'h01, 4);
        e = make_exp(8'h00, 8'h01, 4, cyc + 1);
        q8.push_back(e);
        e.done_cyc = e.done_cyc + d + 2;
        q8.push_back(e);
        repeat (d + 4) @(negedge clk);
        bus8.start = 1'b0;

        // start pulsed while in DONE must not launch a compare
        drive8(8'h80, 8'h00, 1'b0);
        @(negedge clk);
        chk("in_done_phase", bus8.done, 1'b1);
        bus8.op_a  = 8'h00;
        bus8.op_b  = 8'hFF;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        chk("done_start_ignored", bus8.busy, 1'b0);

        // reset at the second COMPARE cycle aborts without a result
        wait_idle8();
        bus8.op_a  = 8'h55;
        bus8.op_b  = 8'h56;
        bus8.start = 1'b1;
        @(negedge clk);
        bus8.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", bus8.busy, 1'b0);
        chk("abort_done", bus8.done, 1'b0);
        chk("abort_res", {bus8.lt, bus8.gt, bus8.eq}, 3'b000);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 30; i++) drive8(8'($urandom), 8'($urandom), i[0]);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                drive4(4'(a), 4'(b));

        n = 0;
        while ((q8.size() != 0 || q4.size() != 0 || bus8.busy || bus4.busy) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("drain", q8.size() + q4.size(), 0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_cmp_ctrl.md
SERIAL_CMP_CTRL -- requirements
Module: serial_cmp_ctrl

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be as listed below.
- WIDTH: default 8; operand width in bits; SHALL be even and >= 2.
- DIGITS: default WIDTH/2; number of 2-bit digits examined.
REQ-003 Ports SHALL be as listed below.
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous active-high reset.
- start, input, 1: request a comparison; sampled only in IDLE.
- op_a, input, WIDTH: operand A; captured on an accepted start.
- op_b, input, WIDTH: operand B; captured on an accepted start.
- busy, output, 1: high while state is not IDLE.
- done, output, 1: one-cycle pulse when the result becomes valid.
- lt, output, 1: A < B (unsigned).
- gt, output, 1: A > B (unsigned).
- eq, output, 1: A == B.

Function
REQ-004 The FSM SHALL have three states: IDLE, COMPARE and DONE.
REQ-005 IDLE -> COMPARE SHALL occur at the edge where start=1: op_a and op_b are latched, the digit index is set to DIGITS-1, and lt/gt/eq are cleared to 0.
REQ-006 In COMPARE, each cycle SHALL examine one digit pair, bits [2k+1:2k] of the latched operands, MSB digit first, through one 2-bit compare slice.
REQ-007 In COMPARE, if the slice reports unequal, then at that edge lt or gt SHALL be registered from the slice and the FSM SHALL go to DONE (early termination).
REQ-008 In COMPARE, if the slice reports equal and k>0, then k SHALL decrement and the FSM SHALL stay in COMPARE.
REQ-009 In COMPARE, if the slice reports equal and k=0, then eq=1 SHALL be registered and the FSM SHALL go to DONE.
REQ-010 In DONE, done SHALL be 1 for exactly one cycle; the FSM SHALL then go to IDLE unconditionally.
REQ-011 lt/gt/eq SHALL be one-hot from the DONE cycle onward and SHALL hold until the next accepted start clears them; they SHALL be all-zero while busy before the decision.
REQ-012 Latency SHALL be as follows, with start accepted at edge N: the decision is taken at edge N+d, where d is the number of digits examined (1..DIGITS); done is high for the cycle after edge N+d; busy falls at edge N+d+1.
REQ-013 start while busy=1, including during DONE, SHALL be ignored; the latched operands SHALL NOT change while busy.
REQ-014 Operand changes on op_a/op_b after acceptance SHALL NOT affect the result.
REQ-015 A start in the first IDLE cycle after DONE SHALL be accepted (back-to-back throughput of d+2 cycles per compare).

Reset
REQ-016 While rst=1 at a clock edge, the state SHALL become IDLE and busy, done, lt, gt, eq SHALL be 0; the operand registers SHALL be 0 and the digit index SHALL be DIGITS-1.
REQ-017 rst SHALL have priority over start.
REQ-018 Reset during COMPARE or DONE SHALL abort the operation with no done pulse and no result.

Structure
REQ-019 A shared package cmp_pkg SHALL hold the state enum (IDLE, COMPARE, DONE) and the default WIDTH constant.
REQ-020 A sub-module cmp2_slice SHALL provide the combinational 2-bit unsigned compare with outputs lt/gt/eq; serial_cmp_ctrl SHALL instantiate exactly one of it.
REQ-021 All state, index, operand and result registers SHALL be in serial_cmp_ctrl; the slice SHALL be purely combinational.

Verification
REQ-022 The bench SHALL cover the following directed scenarios.
- MSB-digit differs: start with A=0xC0, B=0x40 -> gt=1, done exactly one cycle after the accept edge plus one, busy for 2 cycles.
- Equal operands: A=B=0xA5 -> eq=1 after 4 compare cycles, done high for one cycle, lt=gt=0.
- LSB-digit differs: A=0x12, B=0x13 -> lt=1 after 4 compare cycles; op_a/op_b changed to 0xFF during busy -> result unchanged.
- start held high continuously with A=0x00, B=0x01 -> second start accepted only in the IDLE cycle after DONE; a start pulsed during DONE is ignored.
- Reset at the second COMPARE cycle of A=0x55, B=0x56 -> next cycle busy=0, done=0, lt=gt=eq=0, and no done pulse follows.
- Exhaustive sweep at WIDTH=4 (all 256 pairs) -> lt/gt/eq match the unsigned compare and the latency matches REQ-012 for every pair.
